alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_seq.sv | 71 +++++++
 rtl/alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode and FSM state encodings for the pipelined ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_pkg;

    // Operation select codes; 12..15 are unassigned and reported as illegal
    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    // Control FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // True for every assigned opcode
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative shift-add multiplier, one multiplier bit per cycle.
//                Returns the low WIDTH bits of the unsigned product. o_done is
//                high during the cycle whose closing edge retires the last bit;
//                o_product carries the final product in that same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;
    logic [WIDTH-1:0]   w_sum;
    logic               w_last;

    // Partial sum including the current multiplier bit
    always_comb begin
        w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_last = r_run && (r_cnt == c_LAST);
    end

    // Load operands on start, then retire one multiplier bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_done    = w_last;
    assign o_product = w_sum;

endmodule : alu_mul_seq

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
//  Module      : alu_pipe
//  Description : Single-stage registered ALU with valid/ready handshakes.
//                Logic, arithmetic and shift ops complete in one cycle; MUL
//                runs on an iterative multiplier for WIDTH cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    localparam int             c_MSB = WIDTH - 1;
    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_ill;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_illegal;

    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (opcode == OP_MUL);
    assign w_sh        = in_b[SHW-1:0];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter BUSY on an accepted MUL, leave when it finishes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_mul_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output: accept only when idle and the output slot is free or draining
    always_comb begin
        in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    end

    // Single-cycle datapath; MUL result comes from the sequential multiplier
    always_comb begin
        w_sum  = '0;
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        w_ill  = !op_is_legal(opcode);
        case (opcode)
            OP_NOT: w_res = ~in_a;
            OP_AND: w_res = in_a & in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_OR:  w_res = in_a | in_b;
            OP_DEC: begin
                w_sum  = {1'b0, in_a} - c_ONE;
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = in_a[c_MSB] && !w_res[c_MSB];
            end
            OP_ADD: begin
                w_sum  = {1'b0, in_a} + {1'b0, in_b};
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (in_a[c_MSB] == in_b[c_MSB]) && (w_res[c_MSB] != in_a[c_MSB]);
            end
            OP_SUB: begin
                w_sum  = {1'b0, in_a} - {1'b0, in_b};
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (in_a[c_MSB] != in_b[c_MSB]) && (w_res[c_MSB] != in_a[c_MSB]);
            end
            OP_INC: begin
                w_sum  = {1'b0, in_a} + c_ONE;
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = !in_a[c_MSB] && w_res[c_MSB];
            end
            OP_SHL: w_res = in_a << w_sh;
            OP_SHR: w_res = in_a >> w_sh;
            OP_SAR: w_res = $unsigned($signed(in_a) >>> w_sh);
            default: w_res = '0;
        endcase
    end

    // Output register: load on single-cycle accept or MUL completion, else drain or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept && (opcode != OP_MUL)) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_cout      <= w_cout;
            r_zero      <= (w_res == '0);
            r_neg       <= w_res[c_MSB];
            r_ovf       <= w_ovf;
            r_illegal   <= w_ill;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_prod;
            r_cout      <= 1'b0;
            r_zero      <= (w_mul_prod == '0);
            r_neg       <= w_mul_prod[c_MSB];
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

endmodule : alu_pipe

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH=16) with an
//                arithmetic reference model of every opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_pipe;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         ill;
    } out_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        return {result, cout, zero, neg, ovf, illegal};
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed views
    function automatic out_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        out_t   m;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        longint sr = 0;
        int     sh = int'(b[3:0]);
        bit     arith = 1'b0;
        m = '0;
        case (op)
            4'd0:  r = 65535 - ua;
            4'd1:  r = ua & ub;
            4'd2:  r = ua ^ ub;
            4'd3:  r = ua | ub;
            4'd4:  begin r = ua - 1;  sr = sa - 1;  arith = 1'b1; end
            4'd5:  begin r = ua + ub; sr = sa + sb; arith = 1'b1; end
            4'd6:  begin r = ua - ub; sr = sa - sb; arith = 1'b1; end
            4'd7:  begin r = ua + 1;  sr = sa + 1;  arith = 1'b1; end
            4'd8:  r = ua << sh;
            4'd9:  r = ua >> sh;
            4'd10: r = sa >>> sh;
            4'd11: r = ua * ub;
            default: begin r = 0; m.ill = 1'b1; end
        endcase
        m.res = r[W-1:0];
        if (arith) begin
            m.cout = (r < 0) || (r > 65535);
            m.ovf  = (sr > 32767) || (sr < -32768);
        end
        m.zero = (m.res == 0);
        m.neg  = m.res[W-1];
        return m;
    endfunction

    // Present a request and hold it until the edge that accepts it; returns at edge+1
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        opcode   = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        opcode    = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        n_checks++;
        if (observed() !== out_t'('0) || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h valid=%b, required 0 valid=0", observed(), out_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0]   d_op [5] = '{4'd5, 4'd6, 4'd6, 4'd10, 4'd15};
        logic [W-1:0] d_a  [5] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 16'h1234};
        logic [W-1:0] d_b  [5] = '{16'h0001, 16'h0001, 16'h0002, 16'h0013, 16'h5678};
        out_t         d_e  [5] = '{
            out_t'({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}),
            out_t'({16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}),
            out_t'({16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}),
            out_t'({16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}),
            out_t'({16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1})
        };
        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            n_checks++;
            if (out_valid !== 1'b1 || observed() !== d_e[i]) begin
                n_errors++;
                $display("FAIL directed_%0d: valid=%b out=%h, required valid=1 out=%h", i, out_valid, observed(), d_e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        out_t         exp;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd11) op = 4'd5;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            exp      = model(op, a, b);
            opcode   = op;
            in_a     = a;
            in_b     = b;
            in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_ready_%0d: got %b, required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || observed() !== exp) begin
                n_errors++;
                $display("FAIL b2b_result_%0d op=%0d a=%h b=%h: valid=%b out=%h, required valid=1 out=%h",
                         i, op, a, b, out_valid, observed(), exp);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] a;
        logic [W-1:0] b;
        out_t         exp;
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            a   = (t == 0) ? 16'h00FF : W'($urandom);
            b   = (t == 0) ? 16'h0101 : W'($urandom);
            exp = model(4'd11, a, b);
            issue(4'd11, a, b);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mul_start_%0d: in_ready=%b valid=%b, required 0 0", t, in_ready, out_valid);
            end
            for (int k = 1; k <= W; k++) begin
                in_a   = W'($urandom);
                in_b   = W'($urandom);
                opcode = 4'($urandom);
                @(posedge clk);
                #1;
                n_checks++;
                if (k < W) begin
                    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                        n_errors++;
                        $display("FAIL mul_busy_%0d_c%0d: valid=%b in_ready=%b, required 0 0", t, k, out_valid, in_ready);
                    end
                end else begin
                    if (out_valid !== 1'b1 || observed() !== exp || in_ready !== 1'b1) begin
                        n_errors++;
                        $display("FAIL mul_result_%0d a=%h b=%h: valid=%b out=%h in_ready=%b, required 1 %h 1",
                                 t, a, b, out_valid, observed(), in_ready, exp);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_t e1;
        out_t e2;
        e1 = model(4'd5, 16'h1111, 16'h2222);
        e2 = model(4'd5, 16'h7FFF, 16'h0001);
        out_ready = 1'b0;
        issue(4'd5, 16'h1111, 16'h2222);
        opcode   = 4'd5;
        in_a     = 16'h7FFF;
        in_b     = 16'h0001;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || observed() !== e1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold_c%0d: valid=%b out=%h in_ready=%b, required 1 %h 0", c, out_valid, observed(), in_ready, e1);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_ready_rise: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || observed() !== e2) begin
            n_errors++;
            $display("FAIL bp_second: valid=%b out=%h, required 1 %h", out_valid, observed(), e2);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_consume: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        out_t eill;
        eill = out_t'({16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        out_ready = 1'b1;
        issue(4'd11, 16'h1234, 16'h5678);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || observed() !== out_t'('0) || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmul_outputs: valid=%b out=%h in_ready=%b, required 0 0 0", out_valid, observed(), in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmul_ready: in_ready=%b, required 1", in_ready);
        end
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL rstmul_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        issue(4'hF, 16'hABCD, 16'h1234);
        n_checks++;
        if (out_valid !== 1'b1 || observed() !== eill) begin
            n_errors++;
            $display("FAIL rstmul_illegal: valid=%b out=%h, required 1 %h", out_valid, observed(), eill);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_pipe

`default_nettype wire
